rrb_grant_scheduler: RTL and testbench

RRB_GRANT_SCHEDULER -- requirements
Module: rrb_grant_scheduler

---
 rtl/rrb_grant_scheduler.sv | 137 +++++++++++++
 tb/tb_rrb_grant_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rrb_grant_scheduler.sv
// Round-robin grant scheduler with hold-time limit.
// One requester at a time owns the resource. A grant ends on done, when the
// holder drops its request, or when the hold limit expires (timeout preempt).
// Every release is followed by exactly one IDLE cycle before the next grant.
// Outputs are all registered; state is exposed on busy_dbg for checkers.
//
// Handshake: req is level-sensitive. A requester keeps req high until it sees
// its bit in grant, and holds it while it uses the resource. The holder ends
// its grant either by pulsing done or by dropping its req bit. done is only
// meaningful while grant_valid is high; it is ignored while idle.
module rrb_grant_scheduler #(
  parameter int CHANNELS = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         req,
  input  logic                        done,
  output logic [CHANNELS-1:0]         grant,
  output logic                        grant_valid,
  output logic [$clog2(CHANNELS)-1:0] grant_id,
  output logic                        preempt,
  output logic [7:0]                  hold_cnt,
  output logic                        busy_dbg
);

  localparam int ID_W = $clog2(CHANNELS);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic                grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                preempt_q, preempt_d;
  logic [7:0]          hold_cnt_q, hold_cnt_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  int                  cand;
  logic                holder_req;
  logic                timeout;
  logic [ID_W-1:0]     ptr_next;

  // Round-robin winner: first set req bit at or above ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = (int'(ptr_q) + i) % CHANNELS;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = ID_W'(cand);
      end
    end
  end

  // Next-state and registered-output values for the IDLE/BUSY FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;

    holder_req = req[grant_id_q];
    timeout    = (hold_cnt_q == HOLD_LAST);
    ptr_next   = (grant_id_q == ID_W'(CHANNELS - 1)) ? '0 : grant_id_q + 1'b1;

    case (state_q)
      IDLE: begin
        grant_d    = '0;
        grant_id_d = '0;
        hold_cnt_d = '0;
        if (win_found) begin
          state_d    = BUSY;
          grant_d    = ONE_HOT0 << win_id;
          grant_id_d = win_id;
        end
      end
      BUSY: begin
        if (done || !holder_req || timeout) begin
          // done wins over a coincident timeout, so preempt only flags a
          // release the holder did not ask for.
          state_d    = IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          hold_cnt_d = '0;
          ptr_d      = ptr_next;
          preempt_d  = timeout && !done && holder_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    grant_valid_d = |grant_d;
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      preempt_q     <= 1'b0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      preempt_q     <= preempt_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign preempt     = preempt_q;
  assign hold_cnt    = hold_cnt_q;
  assign busy_dbg    = (state_q == BUSY);

endmodule

// File: tb/tb_rrb_grant_scheduler.sv
// Bench for rrb_grant_scheduler (8 channels, hold limit 16).
module tb_rrb_grant_scheduler;

  localparam int N    = 8;
  localparam int MAXH = 16;
  localparam int W    = 22;  // {busy, grant, valid, id, preempt, hold}

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [2:0]   grant_id;
  logic         preempt;
  logic [7:0]   hold_cnt;
  logic         busy_dbg;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_q[$];

  // reference model state
  bit m_busy;
  int m_ptr;
  int m_owner;
  int m_held;
  bit m_pre;

  rrb_grant_scheduler #(.CHANNELS(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .preempt(preempt), .hold_cnt(hold_cnt), .busy_dbg(busy_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // advance the reference model by one clock edge and queue expectations
  task automatic model_edge(input logic [N-1:0] r, input logic d, input logic rst);
    int w;
    logic [W-1:0] e;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_owner = 0; m_held = 0; m_pre = 0;
    end else if (!m_busy) begin
      m_pre = 0;
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_held = 0;
      end
    end else begin
      if (d || !r[m_owner] || m_held == MAXH - 1) begin
        m_pre  = !d && r[m_owner];
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
        m_held = 0;
      end else begin
        m_pre  = 0;
        m_held = m_held + 1;
      end
    end
    e = {m_busy,
         m_busy ? N'(1 << m_owner) : N'(0),
         m_busy,
         m_busy ? 3'(m_owner) : 3'd0,
         m_pre,
         m_busy ? 8'(m_held) : 8'd0};
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // scoreboard: compare DUT outputs with the oldest model expectation
  task automatic score;
    logic [W-1:0] e;
    logic [W-1:0] a;
    e = exp_q.pop_front();
    a = {busy_dbg, grant, grant_valid, grant_id, preempt, hold_cnt};
    check("model", 32'(a), 32'(e));
    n_checks++;
    if ((grant & (grant - 1'b1)) != '0) begin
      n_fail++;
      $display("FAIL onehot: grant %0h has more than one bit", grant);
    end
  endtask

  // driver: apply inputs for one cycle, then score after the edge
  task automatic step(input logic [N-1:0] r, input logic d, input logic rst);
    req = r; done = d; reset = rst;
    @(posedge clk);
    model_edge(r, d, rst);
    #1;
    score();
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] exp_grant;
    logic         exp_pre;
    logic [7:0]   exp_hold;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic [N-1:0] r, input logic d,
                         input logic [N-1:0] g, input logic p, input logic [7:0] h);
    vec_t v;
    v.rst = rst; v.req = r; v.done = d; v.exp_grant = g; v.exp_pre = p; v.exp_hold = h;
    vecs.push_back(v);
  endtask

  task automatic apply_vecs;
    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].done, vecs[i].rst);
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(vecs[i].exp_grant != 0));
      check($sformatf("vec%0d_pre", i), 32'(preempt), 32'(vecs[i].exp_pre));
      check($sformatf("vec%0d_hold", i), 32'(hold_cnt), 32'(vecs[i].exp_hold));
    end
    vecs.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    req = '0; done = 1'b0; reset = 1'b1;

    // reset with requests pending, then full rotation with done after each grant
    add_vec(1, 8'hFF, 0, 8'h00, 0, 8'd0);
    add_vec(1, 8'hFF, 0, 8'h00, 0, 8'd0);
    for (int k = 0; k <= N; k++) begin
      add_vec(0, 8'hFF, 0, N'(1 << (k % N)), 0, 8'd0);
      add_vec(0, 8'hFF, 1, 8'h00, 0, 8'd0);
    end
    // sparse fairness from ptr 0
    add_vec(1, 8'h00, 0, 8'h00, 0, 8'd0);
    add_vec(0, 8'h84, 0, 8'h04, 0, 8'd0);
    add_vec(0, 8'h84, 0, 8'h04, 0, 8'd1);
    add_vec(0, 8'h84, 1, 8'h00, 0, 8'd0);
    add_vec(0, 8'h84, 0, 8'h80, 0, 8'd0);
    add_vec(0, 8'h84, 1, 8'h00, 0, 8'd0);
    add_vec(0, 8'h84, 0, 8'h04, 0, 8'd0);
    add_vec(0, 8'h84, 1, 8'h00, 0, 8'd0);
    // done while idle is ignored, idle without requests keeps ptr (next is 80)
    add_vec(0, 8'h00, 1, 8'h00, 0, 8'd0);
    add_vec(0, 8'h00, 0, 8'h00, 0, 8'd0);
    add_vec(0, 8'h84, 0, 8'h80, 0, 8'd0);
    // request drop by holder: release, next winner from ptr 0 is 04
    add_vec(0, 8'h04, 0, 8'h00, 0, 8'd0);
    add_vec(0, 8'h84, 0, 8'h04, 0, 8'd0);
    apply_vecs();

    // timeout: 16 held cycles, preempt pulse, then regrant
    step(8'h00, 0, 1);
    for (int c = 0; c < MAXH; c++) begin
      step(8'h01, 0, 0);
      check("to_grant", 32'(grant), 32'h01);
      check("to_hold", 32'(hold_cnt), 32'(c));
    end
    step(8'h01, 0, 0);
    check("to_release", 32'(grant), 32'h00);
    check("to_preempt", 32'(preempt), 32'd1);
    step(8'h01, 0, 0);
    check("to_regrant", 32'(grant), 32'h01);
    check("to_pre_clear", 32'(preempt), 32'd0);

    // coincident done and timeout: no preempt, ptr moves to 1
    for (int c = 1; c < MAXH; c++) step(8'h01, 0, 0);
    check("co_hold15", 32'(hold_cnt), 32'(MAXH - 1));
    step(8'h01, 1, 0);
    check("co_release", 32'(grant), 32'h00);
    check("co_preempt", 32'(preempt), 32'd0);
    step(8'h03, 0, 0);
    check("co_ptr", 32'(grant), 32'h02);

    // mid-grant reset: hold 08, reset clears, then rotation restarts at 01
    step(8'h02, 1, 0);
    step(8'h08, 0, 0);
    check("mr_grant08", 32'(grant), 32'h08);
    step(8'hFF, 0, 1);
    check("mr_zero", 32'({grant, grant_valid, grant_id, preempt, hold_cnt}), 32'd0);
    step(8'hFF, 0, 0);
    check("mr_first", 32'(grant), 32'h01);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) r = '0;
      if ($urandom_range(0, 5) == 0) r = 8'h01;  // long holds reach timeout
      step(r, $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
